// File: rtl/uart_pkg.sv
// Shared UART types: parity mode encoding and receiver state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // 2-of-3 vote used by the receiver's noise-tolerant sampling mode
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready holding register and per-word error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  rx_busy
);

    localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic        PAR_EN  = (PARITY != 32'(PARITY_NONE));
    localparam logic        PAR_ODD = (PARITY == 32'(PARITY_ODD));

    logic                  w_rx_s;
    logic                  w_bit;
    logic                  w_half_pt;
    logic                  w_full_pt;
    logic                  w_last_bit;
    logic                  w_par_exp;

    rx_state_e             r_state,  w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift,  w_shift_nxt;
    logic                  r_perr,   w_perr_nxt;
    logic                  r_ferr,   w_ferr_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr_out;
    logic                  r_ferr_out;
    logic                  r_ovr;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // rx_s as seen on the two previous ticks; with the current value forms the vote
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (baud_tick) begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = majority3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_half_pt  = (r_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
    assign w_full_pt  = (r_cnt == CNT_W'(OVERSAMPLE - 1));
    assign w_last_bit = (r_idx == IDX_W'(DATA_WIDTH - 1));
    assign w_par_exp  = (^r_shift) ^ PAR_ODD;

    // Frame FSM: next state and datapath updates, all advancing on baud_tick only
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_done_nxt  = 1'b0;

        if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (w_half_pt) begin
                        w_cnt_nxt = '0;
                        if (!w_bit) begin
                            w_state_nxt = DATA;
                            w_idx_nxt   = '0;
                            w_perr_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_full_pt) begin
                        w_cnt_nxt          = '0;
                        w_shift_nxt[r_idx] = w_bit;
                        if (w_last_bit) begin
                            w_state_nxt = PAR_EN ? uart_pkg::PARITY : STOP;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_full_pt) begin
                        w_cnt_nxt   = '0;
                        w_perr_nxt  = (w_bit != w_par_exp);
                        w_state_nxt = STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // leave at mid-stop so a back-to-back start edge is not missed
                    if (w_full_pt) begin
                        w_cnt_nxt   = '0;
                        w_ferr_nxt  = !w_bit;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Holding register: load on completion if empty or being drained, else flag overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_done) begin
                if (!r_valid || data_ready) begin
                    r_data     <= r_shift;
                    r_valid    <= 1'b1;
                    r_perr_out <= r_perr;
                    r_ferr_out <= r_ferr;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid    <= 1'b0;
                r_perr_out <= 1'b0;
                r_ferr_out <= 1'b0;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign parity_err  = r_perr_out;
    assign frame_err   = r_ferr_out;
    assign overrun_err = r_ovr;
    assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frame driver, expected-word scoreboard and directed cases.
module tb_uart_rx;

    localparam int unsigned DW       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned PAR      = 1;
    localparam int unsigned TICK_DIV = 4;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          baud_tick  = 1'b0;
    logic          rx         = 1'b1;
    logic          data_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;
    logic          rx_busy;

    int            n_cmp   = 0;
    int            n_fail  = 0;
    int            tdiv    = 0;
    int            ovr_exp = 0;
    int            ovr_seen = 0;
    int            n_loaded = 0;
    word_t         exp_q[$];

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_ovr   = 1'b0;
    logic [7:0]    held_d     = 8'h00;
    logic          held_pe    = 1'b0;
    logic          held_fe    = 1'b0;
    logic [7:0]    last_d     = 8'h00;
    logic          last_pe    = 1'b0;
    logic          last_fe    = 1'b0;

    uart_rx #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS),
        .PARITY     (PAR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #10 clk = ~clk;

    // oversample tick: one clk high every TICK_DIV clks
    always @(posedge clk) begin
        if (tdiv == TICK_DIV - 1) begin
            tdiv      <= 0;
            baud_tick <= 1'b1;
        end else begin
            tdiv      <= tdiv + 1;
            baud_tick <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each newly presented word must be the next expected one; held words stay put
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_ovr   <= 1'b0;
        end else begin
            if (data_valid && (!prev_valid || prev_ready)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word at %0t", data_out, $time);
                end else begin
                    check("word_data", 32'(data_out), 32'(exp_q[0].d));
                    check("word_perr", 32'(parity_err), 32'(exp_q[0].pe));
                    check("word_ferr", 32'(frame_err), 32'(exp_q[0].fe));
                    held_d  <= exp_q[0].d;
                    held_pe <= exp_q[0].pe;
                    held_fe <= exp_q[0].fe;
                    exp_q.delete(0);
                end
                last_d   <= data_out;
                last_pe  <= parity_err;
                last_fe  <= frame_err;
                n_loaded <= n_loaded + 1;
            end else if (data_valid) begin
                check("hold_data", 32'(data_out), 32'(held_d));
                check("hold_perr", 32'(parity_err), 32'(held_pe));
                check("hold_ferr", 32'(frame_err), 32'(held_fe));
            end else begin
                check("empty_perr", 32'(parity_err), 32'(0));
                check("empty_ferr", 32'(frame_err), 32'(0));
            end
            if (overrun_err) begin
                ovr_seen <= ovr_seen + 1;
                check("ovr_one_clk", 32'(prev_ovr), 32'(0));
                check("ovr_held_valid", 32'(data_valid), 32'(1));
            end
            prev_valid <= data_valid;
            prev_ready <= data_ready;
            prev_ovr   <= overrun_err;
        end
    end

    // returns just after the clk edge that raised the n-th baud_tick from now
    task automatic tick_wait(input int n);
        repeat (n) begin
            do begin
                @(posedge clk);
                #1;
            end while (!baud_tick);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick_wait(OS);
    endtask

    // expected flags from bit counts: even parity wants an even number of ones over data+parity
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic drop);
        if (drop) ovr_exp++;
        else exp_q.push_back(word_t'{d: d, pe: (($countones({d, pbit}) % 2) == 1), fe: !sbit});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(sbit);
        rx = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d, input logic drop);
        send_frame(d, 1'(($countones(d) % 2) == 1), 1'b1, drop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [8];
        int         n0;
        logic [7:0] d6;
        bytes = '{8'h55, 8'hAA, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h3C, 8'hC3};

        // reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_perr", 32'(parity_err), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_ovr", 32'(overrun_err), 32'(0));
        check("rst_busy", 32'(rx_busy), 32'(0));
        rst = 1'b0;
        tick_wait(4);

        // 1: back-to-back loopback frames, consumer always ready
        data_ready = 1'b1;
        n0 = n_loaded;
        foreach (bytes[i]) good_frame(bytes[i], 1'b0);
        tick_wait(8);
        check("loop_count", 32'(n_loaded - n0), 32'(8));
        check("loop_last", 32'(last_d), 32'(8'hC3));

        // 2: 4-tick low glitch must not start a frame
        n0 = n_loaded;
        rx = 1'b0;
        tick_wait(4);
        rx = 1'b1;
        tick_wait(4);
        check("glitch_busy_mid", 32'(rx_busy), 32'(1));
        tick_wait(2);
        check("glitch_busy_end", 32'(rx_busy), 32'(0));
        tick_wait(8);
        check("glitch_no_word", 32'(n_loaded - n0), 32'(0));

        // 3: wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        tick_wait(4);
        check("par_data", 32'(last_d), 32'(8'hA5));
        check("par_perr", 32'(last_pe), 32'(1));
        check("par_ferr", 32'(last_fe), 32'(0));

        // 4: low stop bit, then a clean frame after idle
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick_wait(2 * OS);
        check("frm_data", 32'(last_d), 32'(8'h3C));
        check("frm_ferr", 32'(last_fe), 32'(1));
        good_frame(8'h81, 1'b0);
        tick_wait(4);
        check("frm_next_data", 32'(last_d), 32'(8'h81));
        check("frm_next_ferr", 32'(last_fe), 32'(0));
        check("frm_next_perr", 32'(last_pe), 32'(0));

        // 5: overrun while the consumer stalls
        data_ready = 1'b0;
        good_frame(8'h11, 1'b0);
        good_frame(8'h22, 1'b1);
        tick_wait(4);
        check("ovr_valid", 32'(data_valid), 32'(1));
        check("ovr_data", 32'(data_out), 32'(8'h11));
        check("ovr_count", 32'(ovr_seen), 32'(1));
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_accept_drop", 32'(data_valid), 32'(0));
        tick_wait(4);

        // 6: reset in the middle of data bit 3 with a word held
        data_ready = 1'b0;
        good_frame(8'h5A, 1'b0);
        d6 = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d6[i]);
        rx = d6[3];
        tick_wait(OS / 2);
        check("pre_rst_valid", 32'(data_valid), 32'(1));
        check("pre_rst_busy", 32'(rx_busy), 32'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(data_valid), 32'(0));
        check("mid_rst_data", 32'(data_out), 32'(0));
        check("mid_rst_busy", 32'(rx_busy), 32'(0));
        check("mid_rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'(0));
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_wait(2 * OS);
        data_ready = 1'b1;
        good_frame(8'hC3, 1'b0);
        tick_wait(4);
        check("post_rst_data", 32'(last_d), 32'(8'hC3));
        check("post_rst_flags", 32'({last_pe, last_fe}), 32'(0));

        // drain and final bookkeeping
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("ovr_total", 32'(ovr_seen), 32'(ovr_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
